// File: rtl/serial_pkg.sv
// serial_pkg -- shared definitions for the serial link (piso_tx / sipo).
//   state_t    : transmitter FSM encoding (IDLE, SHIFT, PAR)
//   cnt_width  : bit-counter width able to hold 0..w
//   even_par   : even-parity bit of a word (zero-extend narrower words)
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   function automatic logic even_par(input logic [63:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/piso_tx.sv
// piso_tx -- parallel-in serial-out transmitter, transmit end of the sipo link.
// A WIDTH-bit word is loaded through a valid/ready handshake and shifted out
// one bit per clock. ld_ready is also high on the final bit, so a word offered
// then streams out with no idle gap.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   ld_data   parallel word to transmit (sampled on the accept edge only)
//   ld_valid  ld_data is valid
//   ld_ready  block can accept a word this cycle (combinational)
//   so        serial data out, 0 whenever so_valid is 0
//   so_valid  so carries a frame bit this cycle
//   so_last   current bit is the final bit of the frame
//   busy      frame in progress
//
// Build option: define PISO_PARITY_EN to append an even-parity bit after the
// data bits (frame length WIDTH+1). Undefined: frame length is WIDTH.
module piso_tx
   import serial_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] ld_data,
   input  logic             ld_valid,
   output logic             ld_ready,
   output logic             so,
   output logic             so_valid,
   output logic             so_last,
   output logic             busy
);

   localparam int             CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             end_bit;
`ifdef PISO_PARITY_EN
   logic             par;
`endif

   // The outgoing bit is whichever end of the register shifting moves toward.
   assign end_bit = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      so        = 1'b0;
      so_valid  = 1'b0;
      so_last   = 1'b0;
      ld_ready  = 1'b0;
      accept    = 1'b0;
      busy      = (state != IDLE);

      case (state)
         IDLE: begin
         end
         SHIFT: begin
            so_valid = 1'b1;
            so       = end_bit;
            if (cnt == LAST_IDX) begin
`ifdef PISO_PARITY_EN
               state_nxt = PAR;
`else
               so_last   = 1'b1;
               state_nxt = IDLE;
`endif
            end
         end
`ifdef PISO_PARITY_EN
         PAR: begin
            so_valid  = 1'b1;
            so        = par;
            so_last   = 1'b1;
            state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase

      // Accepting on the final bit overrides the return to IDLE, which is
      // what gives zero-gap streaming.
      ld_ready = (state == IDLE) | so_last;
      accept   = ld_valid & ld_ready;
      if (accept) begin
         state_nxt = SHIFT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= '0;
         cnt  <= '0;
`ifdef PISO_PARITY_EN
         par  <= 1'b0;
`endif
      end else if (accept) begin
         sreg <= ld_data;
         cnt  <= '0;
`ifdef PISO_PARITY_EN
         par  <= even_par(64'(ld_data));
`endif
      end else if (state == SHIFT) begin
         if (MSB_FIRST) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
         end else begin
            sreg <= {1'b0, sreg[WIDTH-1:1]};
         end
         cnt <= cnt + CW'(1);
`ifdef PISO_PARITY_EN
      end else if (state == PAR) begin
         cnt <= cnt + CW'(1);
`endif
      end
   end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx -- bench for piso_tx (WIDTH=4), one MSB-first and one LSB-first
// instance driven by the same load stream. A frame-position reference model
// predicts every output each cycle; a vector table and hand sequences cover
// the basic, back-to-back, loopback and reset-mid-frame cases.
// Honours PISO_PARITY_EN (frame length 5 when defined).
module tb_piso_tx;

`ifdef PISO_PARITY_EN
   localparam int FL = 5;
`else
   localparam int FL = 4;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] ld_data;
   logic       ld_valid;
   logic       m_ready, m_so, m_sv, m_last, m_busy;
   logic       l_ready, l_so, l_sv, l_last, l_busy;

   piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .ld_data(ld_data), .ld_valid(ld_valid),
      .ld_ready(m_ready), .so(m_so), .so_valid(m_sv), .so_last(m_last), .busy(m_busy)
   );

   piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .ld_data(ld_data), .ld_valid(ld_valid),
      .ld_ready(l_ready), .so(l_so), .so_valid(l_sv), .so_last(l_last), .busy(l_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Receiver stand-in: left-shift assembly of valid MSB-first bits.
   logic [3:0] po;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) po <= 4'h0;
      else if (m_sv) po <= {po[2:0], m_so};
   end

   int total  = 0;
   int passed = 0;

   // Reference model: bits remaining in the current frame and the word being sent.
   int         rem  = 0;
   logic [3:0] word = 4'h0;
   logic       last_acc;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      else passed++;
   endtask

   function automatic logic exp_bit(input bit msb);
      int k;
      k = FL - rem;
      if (k >= 4) return ^word;
      return msb ? word[3-k] : word[k];
   endfunction

   task automatic check_model();
      logic e_sv, e_last, e_rdy;
      e_sv   = (rem > 0);
      e_last = (rem == 1);
      e_rdy  = (rem <= 1);
      chk("msb_so",       {7'd0, m_so},    {7'd0, e_sv ? exp_bit(1'b1) : 1'b0});
      chk("msb_so_valid", {7'd0, m_sv},    {7'd0, e_sv});
      chk("msb_so_last",  {7'd0, m_last},  {7'd0, e_last});
      chk("msb_ld_ready", {7'd0, m_ready}, {7'd0, e_rdy});
      chk("msb_busy",     {7'd0, m_busy},  {7'd0, e_sv});
      chk("lsb_so",       {7'd0, l_so},    {7'd0, e_sv ? exp_bit(1'b0) : 1'b0});
      chk("lsb_so_valid", {7'd0, l_sv},    {7'd0, e_sv});
      chk("lsb_so_last",  {7'd0, l_last},  {7'd0, e_last});
      chk("lsb_ld_ready", {7'd0, l_ready}, {7'd0, e_rdy});
      chk("lsb_busy",     {7'd0, l_busy},  {7'd0, e_sv});
   endtask

   // One clock: model decides acceptance from pre-edge state, then outputs are checked 1ns after the edge.
   task automatic step();
      last_acc = ld_valid && (rem <= 1);
      @(posedge clk);
      if (last_acc) begin
         word = ld_data;
         rem  = FL;
      end else if (rem > 0) begin
         rem--;
      end
      #1;
      check_model();
   endtask

   typedef struct {
      logic       v;
      logic [3:0] d;
      logic       so;
      logic       sv;
      logic       last;
      logic       rdy;
      logic       busy;
   } vec_t;

   vec_t tbl[14];

   initial begin
      rst_n    = 1'b0;
      ld_valid = 1'b1;
      ld_data  = 4'hF;
      #12;
      // Reset state, with ld_valid asserted and ignored.
      chk("rst_so",       {7'd0, m_so},    8'd0);
      chk("rst_so_valid", {7'd0, m_sv},    8'd0);
      chk("rst_so_last",  {7'd0, m_last},  8'd0);
      chk("rst_busy",     {7'd0, m_busy},  8'd0);
      chk("rst_ld_ready", {7'd0, m_ready}, 8'd1);
      ld_valid = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;

      // Expected MSB-first outputs: load B, idle, then A and 5 streamed back-to-back.
      tbl[0]  = '{1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[4]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[9]  = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[13] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

`ifndef PISO_PARITY_EN
      for (int i = 0; i < 14; i++) begin
         ld_valid = tbl[i].v;
         ld_data  = tbl[i].d;
         step();
         chk($sformatf("tbl%0d_so", i),       {7'd0, m_so},    {7'd0, tbl[i].so});
         chk($sformatf("tbl%0d_so_valid", i), {7'd0, m_sv},    {7'd0, tbl[i].sv});
         chk($sformatf("tbl%0d_so_last", i),  {7'd0, m_last},  {7'd0, tbl[i].last});
         chk($sformatf("tbl%0d_ld_ready", i), {7'd0, m_ready}, {7'd0, tbl[i].rdy});
         chk($sformatf("tbl%0d_busy", i),     {7'd0, m_busy},  {7'd0, tbl[i].busy});
      end
`else
      // Parity build: 1011 -> 1,0,1,1 then parity 1; 0000 -> parity 0.
      ld_valid = 1'b1;
      ld_data  = 4'hB;
      step();
      ld_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("par_1011_bit", {7'd0, m_so}, 8'd1);
      chk("par_1011_last", {7'd0, m_last}, 8'd1);
      step();
      ld_valid = 1'b1;
      ld_data  = 4'h0;
      step();
      ld_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("par_0000_bit", {7'd0, m_so}, 8'd0);
      chk("par_0000_sv", {7'd0, m_sv}, 8'd1);
      step();
`endif

      // Loopback: po holds the word on the cycle after the 4th bit.
      ld_valid = 1'b1;
      ld_data  = 4'h6;
      step();
      ld_valid = 1'b0;
      ld_data  = 4'h0;
      for (int i = 0; i < 4; i++) step();
      chk("loopback_po", {4'd0, po}, 8'h06);
      for (int i = 0; i < 2; i++) step();

      // Reset mid-frame: after 2 bits of F, outputs drop without a clock edge.
      ld_valid = 1'b1;
      ld_data  = 4'hF;
      step();
      ld_valid = 1'b0;
      step();
      #2;
      rst_n = 1'b0;
      rem   = 0;
      #1;
      chk("amid_so",       {7'd0, m_so},    8'd0);
      chk("amid_so_valid", {7'd0, m_sv},    8'd0);
      chk("amid_busy",     {7'd0, m_busy},  8'd0);
      chk("amid_ld_ready", {7'd0, m_ready}, 8'd1);
      chk("amid_lsb_sv",   {7'd0, l_sv},    8'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step();

      // Randomized traffic; the source holds each word until it is accepted.
      for (int n = 0; n < 400; n++) begin
         if (!ld_valid && $urandom_range(0, 3) != 0) begin
            ld_valid = 1'b1;
            ld_data  = 4'($urandom);
         end
         step();
         if (last_acc) begin
            ld_valid = 1'b0;
            ld_data  = 4'($urandom);
         end
      end
      ld_valid = 1'b0;
      for (int i = 0; i < FL + 2; i++) step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
